// File: rtl/wav_pkg.sv
// Shared WAV parser definitions: chunk ids as little-endian words, FSM encoding
// and the fmt-chunk constants.
package wav_pkg;

   typedef enum logic [2:0] {
      S_RIFF = 3'd0,
      S_WAVE = 3'd1,
      S_CHDR = 3'd2,
      S_FMT  = 3'd3,
      S_SKIP = 3'd4,
      S_DATA = 3'd5,
      S_DONE = 3'd6,
      S_ERR  = 3'd7
   } wav_state_e;

   // First byte on the wire lands in bits [7:0].
   localparam logic [31:0] ID_RIFF = 32'h4646_4952;
   localparam logic [31:0] ID_WAVE = 32'h4556_4157;
   localparam logic [31:0] ID_FMT  = 32'h2074_6d66;
   localparam logic [31:0] ID_DATA = 32'h6174_6164;

   localparam logic [15:0] WAV_FMT_PCM  = 16'd1;
   localparam logic [31:0] FMT_MIN_SIZE = 32'd16;

endpackage

// File: rtl/le_shift32.sv
// Four-byte little-endian accumulator. peek_o shows the word as it will look
// once the byte currently on byte_i is shifted in; clr_i with shift_i restarts at that byte.
module le_shift32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        shift_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic [31:0] peek_o,
   output logic [2:0]  cnt_o
);

   logic [31:0] word_q;
   logic [2:0]  cnt_q;

   assign peek_o = {byte_i, (clr_i ? 24'h0 : word_q[31:8])};
   assign word_o = word_q;
   assign cnt_o  = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q <= 32'h0;
         cnt_q  <= 3'd0;
      end else if (clr_i || shift_i) begin
         word_q <= shift_i ? peek_o : 32'h0;
         if (clr_i)
            cnt_q <= shift_i ? 3'd1 : 3'd0;
         else if (cnt_q != 3'd4)
            cnt_q <= cnt_q + 3'd1;
      end
   end

endmodule

// File: rtl/wav_stream_parser.sv
// RIFF/WAVE header walker between the flash reader and the byte assembler:
// validates the header, latches fmt fields and forwards only data-chunk payload.
//
//  state  | meaning
//  S_RIFF | "RIFF" magic, then 4 ignored size bytes
//  S_WAVE | "WAVE" form type
//  S_CHDR | 4-byte chunk id + 4-byte chunk size
//  S_FMT  | fmt body: format, channels, rate, bits; extra bytes + pad skipped
//  S_SKIP | unknown chunk body plus pad byte
//  S_DATA | payload forwarded byte by byte
//  S_DONE | payload complete, input ignored
//  S_ERR  | malformed header, input ignored
module wav_stream_parser
   import wav_pkg::*;
#(
   parameter int unsigned EXPECT_BITS   = 16,
   parameter int unsigned MAX_HDR_BYTES = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        restart,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic [7:0]  byte_out,
   output logic        byte_out_valid,
   output logic        hdr_ok,
   output logic        hdr_err,
   output logic        stream_done,
   output logic [15:0] num_channels,
   output logic [31:0] sample_rate,
   output logic [31:0] data_len
);

   localparam int unsigned    IDX_W    = $clog2(MAX_HDR_BYTES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_HDR_BYTES - 1);

   wav_state_e        state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [31:0]       rem_q, rem_d;
   logic              pad_q, pad_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              fmt_seen_q, fmt_seen_d;
   logic [15:0]       chan_q, chan_d;
   logic [31:0]       rate_q, rate_d;
   logic [31:0]       len_q, len_d;
   logic [7:0]        bout_q, bout_d;
   logic              bvalid_q, bvalid_d;
   logic              hdr_ok_q, hdr_err_q, done_q;

   logic              id_clr, id_shift, sz_clr, sz_shift;
   logic [31:0]       id_word, id_peek, sz_peek, sz_word_unused;
   logic [2:0]        id_cnt, sz_cnt;
   logic              chunk_end;

   le_shift32 u_id (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (id_clr),
      .shift_i (id_shift),
      .byte_i  (byte_in),
      .word_o  (id_word),
      .peek_o  (id_peek),
      .cnt_o   (id_cnt)
   );

   le_shift32 u_sz (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (sz_clr),
      .shift_i (sz_shift),
      .byte_i  (byte_in),
      .word_o  (sz_word_unused),
      .peek_o  (sz_peek),
      .cnt_o   (sz_cnt)
   );

   // The pad byte of an odd chunk is consumed once rem has already reached zero.
   assign chunk_end = (rem_q == 32'd0) || ((rem_q == 32'd1) && !pad_q);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      pad_d      = pad_q;
      idx_d      = idx_q;
      fmt_seen_d = fmt_seen_q;
      chan_d     = chan_q;
      rate_d     = rate_q;
      len_d      = len_q;
      bout_d     = bout_q;
      bvalid_d   = 1'b0;
      id_clr     = 1'b0;
      id_shift   = 1'b0;
      sz_clr     = 1'b0;
      sz_shift   = 1'b0;

      if (restart) begin
         state_d    = S_RIFF;
         cnt_d      = 5'd0;
         rem_d      = 32'd0;
         pad_d      = 1'b0;
         idx_d      = '0;
         fmt_seen_d = 1'b0;
         chan_d     = 16'd0;
         rate_d     = 32'd0;
         len_d      = 32'd0;
         bout_d     = 8'd0;
         id_clr     = 1'b1;
         sz_clr     = 1'b1;
      end else if (byte_valid) begin
         if (idx_q != IDX_LAST)
            idx_d = idx_q + 1'b1;

         unique case (state_q)
            S_RIFF: begin
               id_clr   = (cnt_q == 5'd0);
               id_shift = (cnt_q < 5'd4);
               cnt_d    = cnt_q + 5'd1;
               if (id_cnt == 3'd3 && id_peek != ID_RIFF)
                  state_d = S_ERR;
               else if (cnt_q == 5'd7) begin
                  state_d = S_WAVE;
                  cnt_d   = 5'd0;
               end
            end
            S_WAVE: begin
               id_clr   = (cnt_q == 5'd0);
               id_shift = 1'b1;
               cnt_d    = cnt_q + 5'd1;
               if (id_cnt == 3'd3) begin
                  cnt_d   = 5'd0;
                  state_d = (id_peek == ID_WAVE) ? S_CHDR : S_ERR;
               end
            end
            S_CHDR: begin
               id_clr   = (cnt_q == 5'd0);
               id_shift = (cnt_q < 5'd4);
               sz_clr   = (cnt_q == 5'd4);
               sz_shift = (cnt_q >= 5'd4);
               cnt_d    = cnt_q + 5'd1;
               if (sz_cnt == 3'd3) begin
                  cnt_d = 5'd0;
                  rem_d = sz_peek;
                  pad_d = sz_peek[0];
                  if (id_word == ID_FMT)
                     state_d = (sz_peek < FMT_MIN_SIZE) ? S_ERR : S_FMT;
                  else if (id_word == ID_DATA) begin
                     if (!fmt_seen_q)
                        state_d = S_ERR;
                     else begin
                        len_d   = sz_peek;
                        pad_d   = 1'b0;
                        state_d = (sz_peek == 32'd0) ? S_DONE : S_DATA;
                     end
                  end else
                     state_d = (sz_peek == 32'd0) ? S_CHDR : S_SKIP;
               end
            end
            S_FMT: begin
               // Fields are reassembled in u_id; each clear marks the first byte of one.
               id_clr   = (cnt_q == 5'd0) || (cnt_q == 5'd2) ||
                          (cnt_q == 5'd4) || (cnt_q == 5'd14);
               id_shift = (cnt_q < 5'd16);
               if (cnt_q < 5'd16)
                  cnt_d = cnt_q + 5'd1;
               if (rem_q != 32'd0)
                  rem_d = rem_q - 32'd1;
               if (cnt_q == 5'd1 && id_peek[31:16] != WAV_FMT_PCM)
                  state_d = S_ERR;
               if (cnt_q == 5'd3)
                  chan_d = id_peek[31:16];
               if (cnt_q == 5'd7)
                  rate_d = id_peek;
               if (cnt_q == 5'd15) begin
                  if (id_peek[31:16] != 16'(EXPECT_BITS))
                     state_d = S_ERR;
                  else
                     fmt_seen_d = 1'b1;
               end
               if (state_d == S_FMT && chunk_end) begin
                  state_d = S_CHDR;
                  cnt_d   = 5'd0;
               end
            end
            S_SKIP: begin
               if (rem_q != 32'd0)
                  rem_d = rem_q - 32'd1;
               if (chunk_end) begin
                  state_d = S_CHDR;
                  cnt_d   = 5'd0;
               end
            end
            S_DATA: begin
               bout_d   = byte_in;
               bvalid_d = 1'b1;
               rem_d    = rem_q - 32'd1;
               if (rem_q == 32'd1)
                  state_d = S_DONE;
            end
            default: ;
         endcase

         if (state_q != S_DATA && state_q != S_DONE && state_q != S_ERR &&
             idx_q == IDX_LAST && state_d != S_DATA && state_d != S_DONE)
            state_d = S_ERR;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_RIFF;
         cnt_q      <= 5'd0;
         rem_q      <= 32'd0;
         pad_q      <= 1'b0;
         idx_q      <= '0;
         fmt_seen_q <= 1'b0;
         chan_q     <= 16'd0;
         rate_q     <= 32'd0;
         len_q      <= 32'd0;
         bout_q     <= 8'd0;
         bvalid_q   <= 1'b0;
         hdr_ok_q   <= 1'b0;
         hdr_err_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         pad_q      <= pad_d;
         idx_q      <= idx_d;
         fmt_seen_q <= fmt_seen_d;
         chan_q     <= chan_d;
         rate_q     <= rate_d;
         len_q      <= len_d;
         bout_q     <= bout_d;
         bvalid_q   <= bvalid_d;
         hdr_ok_q   <= (state_d == S_DATA) || (state_d == S_DONE);
         hdr_err_q  <= (state_d == S_ERR);
         done_q     <= (state_d == S_DONE);
      end
   end

   assign byte_out       = bout_q;
   assign byte_out_valid = bvalid_q;
   assign hdr_ok         = hdr_ok_q;
   assign hdr_err        = hdr_err_q;
   assign stream_done    = done_q;
   assign num_channels   = chan_q;
   assign sample_rate    = rate_q;
   assign data_len       = len_q;

endmodule
